// File: rtl/uart_tx_port_pkg.sv
// Shared constants for the UART transmit port.
//   tx_state_e  : transmit FSM state encoding
//   DATA_BITS   : data bits per frame
//   FRAME_BITS  : bits per frame (start + data + optional parity + stop)
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
package uart_tx_port_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  localparam int DATA_BITS = 8;

`ifdef UART_TX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

endpackage

// File: rtl/uart_tx_port_if.sv
// Core-side write port of the UART transmitter.
//   cq   : byte to transmit
//   cwre : single-cycle write strobe qualifying cq
//   cbsy : FIFO full, writes are refused while high
// master = the core driving writes, slave = the transmitter.
interface uart_tx_port_if;
  logic [7:0] cq;
  logic       cwre;
  logic       cbsy;

  modport master (output cq, output cwre, input cbsy);
  modport slave  (input cq, input cwre, output cbsy);
endinterface

// File: rtl/uart_tx_port_fifo.sv
// tx_fifo: transmit FIFO, depth 2**FIFO_LOG2, first-word-fall-through head.
//   clk, reset : clock, synchronous active-high reset
//   push, din  : write request and data (ignored when full)
//   pop        : discard head entry (ignored when empty)
//   head       : oldest entry
//   full, empty: registered status flags, valid the cycle after the edge
module tx_fifo #(
  parameter int WIDTH     = 8,
  parameter int FIFO_LOG2 = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 2 ** FIFO_LOG2;
  localparam logic [FIFO_LOG2:0] DEPTH_CNT = {1'b1, {FIFO_LOG2{1'b0}}};

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [FIFO_LOG2-1:0] wr_ptr;
  logic [FIFO_LOG2-1:0] rd_ptr;
  logic [FIFO_LOG2:0]   count;
  logic [FIFO_LOG2:0]   count_next;
  logic                 do_push;
  logic                 do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({do_push, do_pop})
      2'b10:   count_next = count + (FIFO_LOG2 + 1)'(1);
      2'b01:   count_next = count - (FIFO_LOG2 + 1)'(1);
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (do_pop)  rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      count <= count_next;
      full  <= (count_next == DEPTH_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/uart_tx_port.sv
// uart_tx_port: buffered UART transmitter (8 data bits, 1 stop bit, LSB first).
//   clk   : sole clock
//   reset : synchronous active-high reset
//   core  : write port (cq, cwre, cbsy), slave side
//   txd   : serial output, idle high, driven from a flop
// Parameters: CLK_DIV clock cycles per bit (2..65535), FIFO_LOG2 log2 of FIFO depth (1..6).
// Optional feature macro: UART_TX_PARITY_EN adds an even-parity bit after data bit 7.
module uart_tx_port #(
  parameter int CLK_DIV   = 16,
  parameter int FIFO_LOG2 = 2
) (
  input  logic           clk,
  input  logic           reset,
  uart_tx_port_if.slave  core,
  output logic           txd
);
  import uart_tx_port_pkg::*;

  localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);

  tx_state_e   state;
  logic [15:0] div;
  logic [2:0]  idx;
  logic [7:0]  shift;
  logic [7:0]  head;
  logic        fifo_full;
  logic        fifo_empty;
  logic        push;
  logic        pop;
  logic        bit_end;
`ifdef UART_TX_PARITY_EN
  logic        parity;
`endif

  tx_fifo #(
    .WIDTH     (8),
    .FIFO_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (core.cq),
    .head  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign push      = core.cwre & ~fifo_full;
  assign core.cbsy = fifo_full;
  assign bit_end   = (div == 16'd0);

  // The next byte is taken either from idle or at the last cycle of a stop
  // bit, so back-to-back frames have no gap.
  always_comb begin
    pop = 1'b0;
    if (!fifo_empty) begin
      if (state == IDLE)               pop = 1'b1;
      else if (state == STOP && bit_end) pop = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      txd   <= 1'b1;
      div   <= 16'd0;
      idx   <= 3'd0;
      shift <= 8'd0;
`ifdef UART_TX_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          txd <= 1'b1;
          if (pop) begin
            shift <= head;
`ifdef UART_TX_PARITY_EN
            parity <= ^head;
`endif
            txd   <= 1'b0;
            div   <= DIV_RELOAD;
            state <= START;
          end
        end

        START: begin
          if (bit_end) begin
            txd   <= shift[0];
            shift <= shift >> 1;
            idx   <= 3'd0;
            div   <= DIV_RELOAD;
            state <= DATA;
          end else begin
            div <= div - 16'd1;
          end
        end

        DATA: begin
          if (bit_end) begin
            div <= DIV_RELOAD;
            if (idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              txd   <= parity;
              state <= PARITY;
`else
              txd   <= 1'b1;
              state <= STOP;
`endif
            end else begin
              txd   <= shift[0];
              shift <= shift >> 1;
              idx   <= idx + 3'd1;
            end
          end else begin
            div <= div - 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            txd   <= 1'b1;
            div   <= DIV_RELOAD;
            state <= STOP;
          end else begin
            div <= div - 16'd1;
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            if (pop) begin
              shift <= head;
`ifdef UART_TX_PARITY_EN
              parity <= ^head;
`endif
              txd   <= 1'b0;
              div   <= DIV_RELOAD;
              state <= START;
            end else begin
              txd   <= 1'b1;
              state <= IDLE;
            end
          end else begin
            div <= div - 16'd1;
          end
        end

        default: begin
          txd   <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 Parameter CLK_DIV, default 16, clock cycles per UART bit; legal range 2..65535.
REQ-002 Parameter FIFO_LOG2, default 2, log2 of the transmit FIFO depth (depth DEPTH = 2**FIFO_LOG2); legal range 1..6.
REQ-003 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  synchronous, active-high reset.
REQ-005 Port cq  input  8  byte from the core's EXT write port.
REQ-006 Port cwre  input  1  single-cycle write strobe qualifying cq.
REQ-007 Port cbsy  output  1  busy: FIFO full, further writes are refused.
REQ-008 Port txd  output  1  serial line, idle high.

Function
REQ-009 The block SHALL push cq into the FIFO on a rising edge where cwre=1 and cbsy=0.
REQ-010 A write with cwre=1 and cbsy=1 SHALL be discarded with no state change.
REQ-011 cbsy SHALL be a registered output equal to (FIFO count == DEPTH) after that edge's push/pop, visible the cycle after the filling write.
REQ-012 On a cycle with a simultaneous accepted push and pop, count SHALL be unchanged; read/write pointers SHALL wrap modulo DEPTH.
REQ-013 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-014 IDLE: txd=1; when FIFO non-empty, pop the head byte into the shift register, drive txd=0, enter START on the same edge.
REQ-015 Latency: a write accepted at edge N into an empty FIFO with FSM in IDLE SHALL drive txd low from edge N+1.
REQ-016 Each bit (start, 8 data, parity, stop) SHALL hold txd for exactly CLK_DIV cycles, timed by a divider counter reloaded at every bit boundary.
REQ-017 DATA SHALL send bit 0 first (LSB first), using a 3-bit index counting 0..7.
REQ-018 STOP SHALL drive txd=1; at its end, go to START with the next byte if the FIFO is non-empty (no idle gap), else go to IDLE.
REQ-019 A frame once started SHALL complete regardless of cwre activity.
REQ-020 txd SHALL be driven from a flop (glitch-free).

Reset
REQ-021 On reset, the block SHALL set txd=1 and cbsy=0, empty the FIFO, set the FSM to IDLE, and clear the divider and bit index.
REQ-022 Reset asserted mid-frame SHALL abandon the frame, with txd=1 from the next edge; cwre is ignored while reset=1.

Configuration
REQ-023 Macro UART_TX_PARITY_EN: when defined, PARITY SHALL be entered after bit 7 and transmit the even-parity bit (XOR of the 8 data bits) for CLK_DIV cycles, giving an 11-bit frame.
REQ-024 When UART_TX_PARITY_EN is undefined, DATA SHALL go directly to STOP, giving a 10-bit frame, and no parity logic SHALL be synthesised.

Structure
REQ-025 The FSM state encodings and the frame-length constants SHALL live in the shared constants include used by the core stages.
REQ-026 The FIFO SHALL be a separate sub-module, tx_fifo (parameterised by width and FIFO_LOG2, with push, pop, head, full and empty signals); uart_tx_port holds the divider, FSM and shifter.

Verification
REQ-027 Single byte: with CLK_DIV=4, parity off, write 0x42 -> txd=0 for 4 cycles, then 0,1,0,0,0,0,1,0 at 4 cycles each, then 1 for 4 cycles, then idle high; total 40 cycles.
REQ-028 Parity: with UART_TX_PARITY_EN defined, write 0x07 -> parity bit 1; write 0x42 -> parity bit 0; frames are 44 cycles at CLK_DIV=4.
REQ-029 Full/back-pressure: with FIFO_LOG2=2, write 5 bytes on consecutive cycles -> the first byte is popped into the shifter and bytes 2-5 fill the FIFO, so cbsy=1 from the cycle after the 5th write; a 6th write is dropped; cbsy falls after the next pop, and exactly 5 frames are transmitted back-to-back with no idle cycles.
REQ-030 Reset mid-frame: assert reset during bit 3 of 0x55 -> txd=1 and cbsy=0 at the next edge, no further frame; a post-reset write of 0xA5 is sent correctly.
REQ-031 Push/pop coincidence: with the FIFO at count 2, write on the exact cycle STOP ends -> count stays 2 and the byte order is preserved.
